// File: rtl/sample_output_buffer.sv
// Packet-oriented output buffer: captures a generator packet into a circular
// FIFO and streams it to the DAC with a ready/valid handshake.
module sample_output_buffer #(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SIGN_START_CALC,
  input  logic              SIGN_STOP_CALC,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              DAC_READY,
  output logic              OUT_REG_READY,
  output logic [DATA_W-1:0] DAC_DATA,
  output logic              DAC_VALID,
  output logic              PACKET_LAST,
  output logic              OVERFLOW,
  output logic [31:0]       SAMPLE_COUNT
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(FIFO_DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                ready_q, ready_d;
  logic [31:0]         sample_cnt_q, sample_cnt_d;
  logic [DATA_W:0]     mem_q [FIFO_DEPTH];
  logic [DATA_W:0]     head;
  logic                empty, full, push, pop, wr_en;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == DEPTH);
    pop   = !empty && DAC_READY;
    push  = (state_q == CAPTURE);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    wr_en = push && (!full || pop);

    wr_ptr_d     = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d   = overflow_q || (push && !wr_en);
    sample_cnt_d = sample_cnt_q;

    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (SIGN_START_CALC) begin
          state_d      = CAPTURE;
          sample_cnt_d = '0;
        end
      end
      CAPTURE: begin
        sample_cnt_d = sample_cnt_q + 32'd1;
        // The last sample ends capture even if it was dropped on overflow.
        if (SIGN_STOP_CALC) state_d = DRAIN;
      end
      DRAIN: begin
        if (count_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      ready_q      <= 1'b1;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      ready_q      <= ready_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Storage is left unreset; occupancy alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= {SIGN_STOP_CALC, DATA_IN};
  end

  always_comb begin
    head          = mem_q[rd_ptr_q];
    DAC_VALID     = !empty;
    DAC_DATA      = empty ? '0 : head[DATA_W-1:0];
    PACKET_LAST   = !empty && head[DATA_W];
    OUT_REG_READY = ready_q;
    OVERFLOW      = overflow_q;
    SAMPLE_COUNT  = sample_cnt_q;
  end

endmodule

// File: tb/tb_sample_output_buffer.sv
// Bench for sample_output_buffer: packet table plus hand-written corner
// sequences, with a queue scoreboard checking every DAC handshake.
module tb_sample_output_buffer;

  localparam int DATA_W = 12;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              SIGN_START_CALC;
  logic              SIGN_STOP_CALC;
  logic [DATA_W-1:0] DATA_IN;
  logic              DAC_READY;
  logic              OUT_REG_READY;
  logic [DATA_W-1:0] DAC_DATA;
  logic              DAC_VALID;
  logic              PACKET_LAST;
  logic              OVERFLOW;
  logic [31:0]       SAMPLE_COUNT;

  sample_output_buffer #(.DATA_W(DATA_W), .FIFO_DEPTH(16), .ADDR_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .SIGN_START_CALC(SIGN_START_CALC),
    .SIGN_STOP_CALC(SIGN_STOP_CALC), .DATA_IN(DATA_IN), .DAC_READY(DAC_READY),
    .OUT_REG_READY(OUT_REG_READY), .DAC_DATA(DAC_DATA), .DAC_VALID(DAC_VALID),
    .PACKET_LAST(PACKET_LAST), .OVERFLOW(OVERFLOW), .SAMPLE_COUNT(SAMPLE_COUNT)
  );

  always #5 CLK = ~CLK;

  // mode: 0 ready always, 1 ready low during capture, 2 ready low for the
  // first 16 samples, 3 random ready with random data
  typedef struct {
    int   n;
    int   mode;
    int   stored;
    logic ovf;
    int   lasts;
    int   start_at;
    logic drain_start;
    logic pre_reset;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  int pop_cnt, last_cnt;
  logic [DATA_W:0] sb[$];
  logic [DATA_W:0] mon_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic ready_for(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (i >= 16);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Scoreboard: every handshake must match the oldest expected sample.
  always @(negedge CLK) begin
    if (DAC_VALID && DAC_READY) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_pop: got %0h, expected no data", DAC_DATA);
      end else begin
        mon_exp = sb.pop_front();
        chk("dac_data", 32'(DAC_DATA), 32'(mon_exp[DATA_W-1:0]));
        chk("packet_last", 32'(PACKET_LAST), 32'(mon_exp[DATA_W]));
      end
      pop_cnt++;
      if (PACKET_LAST) last_cnt++;
    end else if (!DAC_VALID) begin
      chk("idle_data_zero", 32'({PACKET_LAST, DAC_DATA}), 32'd0);
    end
  end

  task automatic run_vec(input vec_t v, input int vi);
    logic [DATA_W-1:0] d;
    int cyc;
    if (v.pre_reset) begin
      RESET = 1'b1; SIGN_START_CALC = 1'b0; SIGN_STOP_CALC = 1'b0;
      DATA_IN = '0; DAC_READY = 1'b0;
      tick(); tick();
      RESET = 1'b0;
    end
    pop_cnt = 0;
    last_cnt = 0;
    @(negedge CLK);
    chk("idle_ready", 32'(OUT_REG_READY), 32'd1);
    DAC_READY = ready_for(v.mode, 0);
    SIGN_START_CALC = 1'b1;
    tick();
    for (int i = 0; i < v.n; i++) begin
      d = (v.mode == 3) ? DATA_W'($urandom) : DATA_W'(vi * 16 + i + 1);
      DATA_IN = d;
      SIGN_STOP_CALC = (i == v.n - 1);
      SIGN_START_CALC = (i == v.start_at);
      DAC_READY = ready_for(v.mode, i);
      if (i < v.stored) sb.push_back({SIGN_STOP_CALC, d});
      if (i == 0) begin
        @(negedge CLK);
        chk("busy_after_start", 32'(OUT_REG_READY), 32'd0);
        chk("count_cleared", SAMPLE_COUNT, 32'd0);
      end
      tick();
    end
    SIGN_START_CALC = 1'b0;
    SIGN_STOP_CALC = 1'b0;
    DATA_IN = '0;
    if (v.drain_start) begin
      DAC_READY = 1'b0;
      SIGN_START_CALC = 1'b1;
      SIGN_STOP_CALC = 1'b1;
      tick();
      SIGN_START_CALC = 1'b0;
      SIGN_STOP_CALC = 1'b0;
      @(negedge CLK);
      chk("drain_start_busy", 32'(OUT_REG_READY), 32'd0);
      chk("drain_start_count", SAMPLE_COUNT, 32'(v.n));
    end
    cyc = 0;
    while (!OUT_REG_READY && cyc < 300) begin
      DAC_READY = (v.mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      cyc++;
    end
    if (cyc >= 300) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got no OUT_REG_READY in %0d cycles, expected it", cyc);
    end
    @(negedge CLK);
    chk("valid_after_drain", 32'(DAC_VALID), 32'd0);
    chk("overflow", 32'(OVERFLOW), 32'(v.ovf));
    chk("sample_count", SAMPLE_COUNT, 32'(v.n));
    chk("pop_count", 32'(pop_cnt), 32'(v.stored));
    chk("last_count", 32'(last_cnt), 32'(v.lasts));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t tail;
    tbl[0] = '{n: 5,  mode: 0, stored: 5,  ovf: 1'b0, lasts: 1, start_at: -1, drain_start: 1'b0, pre_reset: 1'b1};
    tbl[1] = '{n: 1,  mode: 0, stored: 1,  ovf: 1'b0, lasts: 1, start_at: -1, drain_start: 1'b0, pre_reset: 1'b1};
    tbl[2] = '{n: 24, mode: 2, stored: 24, ovf: 1'b0, lasts: 1, start_at: -1, drain_start: 1'b0, pre_reset: 1'b1};
    tbl[3] = '{n: 40, mode: 3, stored: 40, ovf: 1'b0, lasts: 1, start_at: -1, drain_start: 1'b0, pre_reset: 1'b1};
    tbl[4] = '{n: 6,  mode: 1, stored: 6,  ovf: 1'b0, lasts: 1, start_at: 3,  drain_start: 1'b1, pre_reset: 1'b1};
    tbl[5] = '{n: 20, mode: 1, stored: 16, ovf: 1'b1, lasts: 0, start_at: -1, drain_start: 1'b0, pre_reset: 1'b1};

    RESET = 1'b1; SIGN_START_CALC = 1'b0; SIGN_STOP_CALC = 1'b0;
    DATA_IN = '0; DAC_READY = 1'b1;
    tick(); tick();
    @(negedge CLK);
    chk("rst_ready", 32'(OUT_REG_READY), 32'd1);
    chk("rst_valid", 32'(DAC_VALID), 32'd0);
    chk("rst_overflow", 32'(OVERFLOW), 32'd0);
    chk("rst_sample_count", SAMPLE_COUNT, 32'd0);
    RESET = 1'b0;

    for (int v = 0; v < 6; v++) run_vec(tbl[v], v);

    // Reset on the third sample of a packet, with OVERFLOW still set.
    DAC_READY = 1'b1;
    SIGN_START_CALC = 1'b1;
    tick();
    SIGN_START_CALC = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      DATA_IN = DATA_W'(i);
      sb.push_back({1'b0, DATA_W'(i)});
      tick();
    end
    @(negedge CLK);
    chk("overflow_sticky", 32'(OVERFLOW), 32'd1);
    DATA_IN = DATA_W'(3);
    RESET = 1'b1;
    tick();
    @(negedge CLK);
    chk("midrst_ready", 32'(OUT_REG_READY), 32'd1);
    chk("midrst_valid", 32'(DAC_VALID), 32'd0);
    chk("midrst_data", 32'({PACKET_LAST, DAC_DATA}), 32'd0);
    chk("midrst_overflow", 32'(OVERFLOW), 32'd0);
    chk("midrst_sample_count", SAMPLE_COUNT, 32'd0);
    chk("midrst_scoreboard", 32'(sb.size()), 32'd0);
    sb.delete();
    RESET = 1'b0;
    DATA_IN = '0;
    tick();
    tail = '{n: 3, mode: 0, stored: 3, ovf: 1'b0, lasts: 1, start_at: -1, drain_start: 1'b0, pre_reset: 1'b0};
    run_vec(tail, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
